mem_responder: RTL and testbench

- Word-addressed data/instruction memory responder: the memory-side end of the multicycle core's memory access path.
- Accepts one read or write request at a time through a valid/ready handshake.
- Inserts a programmable number of wait cycles, then returns read data or a write acknowledge through a valid/ready response channel.
- Sits between the multicycle datapath's address/write-data registers and the backing RAM; lets the control FSM stall on memory instead of assuming single-cycle access.

---
 rtl/mem_responder.sv | 144 ++++++++++++++
 tb/tb_mem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory responder: one request at a time over valid/ready,
// programmable wait cycles, then a held read-data / write-ack response.
module mem_responder #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned LATENCY   = 2,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;
    localparam int unsigned DW = 32;
    localparam logic [CW-1:0] CNT_LOAD = (LATENCY == 0) ? '0 : CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            enter_resp;
    logic            accept;

    logic            we_q;
    logic [AW-1:0]   idx_q;
    logic [DW-1:0]   wdata_q;
    logic            err_q;

    logic            err_in;
    logic [AW-1:0]   idx_in;

    logic            sel_we;
    logic [AW-1:0]   sel_idx;
    logic [DW-1:0]   sel_wdata;
    logic            sel_err;

    logic [DW-1:0]   mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : 32'hxxxx_xxxx)};

    assign err_in = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));
    assign idx_in = req_addr[AW+1:2];
    assign accept = req_valid && (state_q == S_IDLE);

    // With zero latency RESP is entered on the acceptance edge, before the latches fill.
    assign sel_we    = (state_q == S_IDLE) ? req_we    : we_q;
    assign sel_idx   = (state_q == S_IDLE) ? idx_in    : idx_q;
    assign sel_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign sel_err   = (state_q == S_IDLE) ? err_in    : err_q;

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign busy       = (state_q != S_IDLE);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and wait counter
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request latches and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                idx_q   <= idx_in;
                wdata_q <= req_wdata;
                err_q   <= err_in;
            end
            if (enter_resp) begin
                resp_err   <= sel_err;
                resp_rdata <= (sel_err || sel_we) ? '0 : mem[sel_idx];
            end
        end
    end

    // Array write commits only on RESP entry; reset leaves contents alone.
    always_ff @(posedge clk) begin
        if (enter_resp && sel_we && !sel_err) begin
            mem[sel_idx] <= sel_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: two instances (latency 2 and 0) checked
// against an array-based memory model with handshake timing expectations.
module tb_mem_responder;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT_A = 2;
    localparam int unsigned LAT_B = 0;

    logic        clk;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid [2];
    logic        resp_ready;
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        busy       [2];

    logic [31:0] model [2][DEPTH];
    int          n_checks = 0;
    int          n_pass   = 0;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A), .INIT_ZERO(1'b1)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
    );

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B), .INIT_ZERO(1'b1)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned lat_of(input int s);
        return (s == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic scramble(input int s);
        req_valid[s] = 1'($urandom_range(0, 1));
        req_we       = 1'($urandom_range(0, 1));
        req_addr     = $urandom;
        req_wdata    = $urandom;
    endtask

    // One full transaction with response held off for 'hold' cycles.
    task automatic txn(input int s, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold);
        logic        exp_e;
        logic [31:0] exp_d;
        int          idx;
        int          edges;
        exp_e = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH));
        idx   = int'(addr[7:2]);
        exp_d = 32'h0;
        if (!exp_e && !we) exp_d = model[s][idx];
        if (!exp_e && we)  model[s][idx] = wd;

        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wd;
        req_valid[s] = 1'b1; resp_ready = 1'b0;
        check("idle_ready", 32'(req_ready[s]), 32'd1);
        @(negedge clk);
        scramble(s);
        check("busy_after_accept", 32'(busy[s]), 32'd1);
        check("ready_after_accept", 32'(req_ready[s]), 32'd0);
        edges = 1;
        while (!resp_valid[s] && edges < 40) begin
            @(negedge clk);
            scramble(s);
            edges++;
        end
        check("latency", 32'(edges), 32'(lat_of(s) + 1));
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(resp_valid[s]), 32'd1);
            check("hold_rdata", resp_rdata[s], exp_d);
            @(negedge clk);
            scramble(s);
        end
        check("resp_valid", 32'(resp_valid[s]), 32'd1);
        check("resp_rdata", resp_rdata[s], exp_d);
        check("resp_err", 32'(resp_err[s]), 32'(exp_e));
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid[s] = 1'b0;
        check("post_ready", 32'(req_ready[s]), 32'd1);
        check("post_valid", 32'(resp_valid[s]), 32'd0);
    endtask

    // Three reads with req_valid and resp_ready held high throughout.
    task automatic b2b(input int s);
        logic [31:0] addrs [3];
        logic [31:0] exp_q [$];
        int acc_n = 0;
        int hs_n = 0;
        int last_hs = -1;
        for (int i = 0; i < 3; i++) begin
            addrs[i] = 32'($urandom_range(0, DEPTH - 1)) << 2;
            exp_q.push_back(model[s][int'(addrs[i][7:2])]);
        end
        @(negedge clk);
        req_we = 1'b0; req_addr = addrs[0]; req_valid[s] = 1'b1; resp_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && hs_n < 3; cyc++) begin
            logic acc;
            acc = req_valid[s] && req_ready[s];
            if (acc) begin
                if (last_hs >= 0) check("b2b_bubble", 32'(cyc - last_hs), 32'd1);
                acc_n++;
            end
            if (resp_valid[s]) begin
                check("b2b_rdata", resp_rdata[s], exp_q[hs_n]);
                check("b2b_err", 32'(resp_err[s]), 32'd0);
                hs_n++;
                last_hs = cyc;
            end
            @(negedge clk);
            if (acc) begin
                if (acc_n < 3) req_addr = addrs[acc_n];
                else req_valid[s] = 1'b0;
            end
        end
        check("b2b_count", 32'(hs_n), 32'd3);
        req_valid[s] = 1'b0;
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] prior;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < int'(DEPTH); i++) model[s][i] = 32'h0;
        reset = 1'b0;
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_ready", 32'(req_ready[s]), 32'd1);
            check("rst_valid", 32'(resp_valid[s]), 32'd0);
            check("rst_busy", 32'(busy[s]), 32'd0);
            check("rst_rdata", resp_rdata[s], 32'h0);
            check("rst_err", 32'(resp_err[s]), 32'd0);
        end
        reset = 1'b1;

        // Directed: write then read back, on both latencies
        for (int s = 0; s < 2; s++) begin
            txn(s, 1'b1, 32'h08, 32'hDEAD_BEEF, 0);
            txn(s, 1'b0, 32'h08, 32'h0, 0);
        end

        // Errors: misaligned and out-of-range must not alias onto word 0
        for (int s = 0; s < 2; s++) begin
            txn(s, 1'b1, 32'h00, 32'hA5A5_0001 + 32'(s), 0);
            txn(s, 1'b0, 32'h0A, 32'h0, 0);
            txn(s, 1'b1, 32'h100, 32'h1111_2222, 0);
            txn(s, 1'b0, 32'h00, 32'h0, 0);
        end

        // Response back-pressure with request inputs wiggling
        txn(0, 1'b0, 32'h08, 32'h0, 5);
        txn(1, 1'b1, 32'h0C, 32'h0BAD_F00D, 5);

        // Reset during WAIT of a write: prior contents survive
        txn(0, 1'b1, 32'h04, 32'hCAFE_0004, 0);
        prior = model[0][1];
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h04; req_wdata = 32'h1234_5678; req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("wait_busy", 32'(busy[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_ready", 32'(req_ready[0]), 32'd1);
        check("abort_valid", 32'(resp_valid[0]), 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        txn(0, 1'b0, 32'h04, 32'h0, 0);
        check("abort_model", model[0][1], prior);

        // Back-to-back reads
        b2b(0);
        b2b(1);

        // Randomized mix against the model
        for (int n = 0; n < 60; n++) begin
            int s;
            logic [31:0] a;
            s = int'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 71)) << 2;
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            txn(s, 1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
